irq_pending_encoder: RTL

- Upstream neighbour of the 8-to-3 active-low priority encoder.
- Captures eight asynchronous active-low interrupt lines (irq_in_b) and synchronizes them, then latches falling edges into a pending register.
- Presents the highest-priority unmasked pending source as a 3-bit index over a valid/ready handshake.
- A downstream consumer, such as the 3-to-8 decoder that drives acknowledge strobes, accepts the index.

---
 rtl/irq_pending_encoder_pkg.sv | 10 +
 rtl/irq_pending_encoder_sync_edge.sv | 26 ++
 rtl/irq_pending_encoder.sv | 75 +++++++
 3 files changed

// File: rtl/irq_pending_encoder_pkg.sv
// irq_pkg: shared sizes, presentation FSM states and the fixed-priority pick for irq_pending_encoder
package irq_pkg;
  localparam int NUM_SRC = 8;
  localparam int IDX_W = 3;
  typedef enum logic {IDLE, PRESENT} irq_state_t;
  function automatic logic [IDX_W-1:0] prio_lowest(input logic [NUM_SRC-1:0] v);
    prio_lowest = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) if (v[i]) prio_lowest = IDX_W'(i);
  endfunction
endpackage

// File: rtl/irq_pending_encoder_sync_edge.sv
// irq_sync_edge: synchronize one active-low request and flag its falling edge
// ports: clk, rst_b (async active-low), irq_b (raw, active-low) -> sync_level_b (synchronized level), fall_edge (1-cycle pulse)
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_b,
  input  logic irq_b,
  output logic sync_level_b,
  output logic fall_edge
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic hist_q;
  // all flops reset inactive so releasing reset with a low input still yields one real edge, never a false one
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_b};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end
  assign sync_level_b = sync_q[SYNC_STAGES-1];
  assign fall_edge = hist_q & ~sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/irq_pending_encoder.sv
// irq_pending_encoder: latch 8 active-low interrupts into pending and present the highest-priority unmasked index over valid/ready
// ports: clk, rst_b (async active-low); irq_in_b, mask, en_b, ovf_clr, irq_ready in;
//        irq_valid, irq_idx, irq_any_b, pending, overflow out
module irq_pending_encoder
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic [NUM_SRC-1:0] irq_in_b,
  input  logic [NUM_SRC-1:0] mask,
  input  logic               en_b,
  input  logic               ovf_clr,
  input  logic               irq_ready,
  output logic               irq_valid,
  output logic [IDX_W-1:0]   irq_idx,
  output logic               irq_any_b,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] overflow
);
  logic [NUM_SRC-1:0] lvl_b, fall, elig, clr, pend_q, pend_d, ovf_q, ovf_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  irq_state_t state_q, state_d;
  logic hs;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk          (clk),
      .rst_b        (rst_b),
      .irq_b        (irq_in_b[i]),
      .sync_level_b (lvl_b[i]),
      .fall_edge    (fall[i])
    );
  end
  assign elig = pend_q & ~mask;
  assign hs = irq_valid & irq_ready;
  assign clr = hs ? {{(NUM_SRC-1){1'b0}}, 1'b1} << idx_q : '0;
  // an edge coinciding with its own clear keeps the bit set and is not an overflow
  always_comb begin
    pend_d = EDGE_MODE ? (fall | (pend_q & ~clr)) : ~lvl_b;
    ovf_d = EDGE_MODE ? ((fall & pend_q & ~clr) | (ovf_clr ? '0 : ovf_q)) : '0;
  end
  // index is captured once on entry to PRESENT and held until handshake or withdrawal
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    if (state_q == IDLE) begin
      if (!en_b && |elig) begin
        state_d = PRESENT;
        idx_d = prio_lowest(elig);
      end
    end else if (hs || en_b) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      idx_q <= '0;
      pend_q <= '0;
      ovf_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      pend_q <= pend_d;
      ovf_q <= ovf_d;
    end
  end
  assign irq_valid = (state_q == PRESENT);
  assign irq_idx = idx_q;
  assign irq_any_b = ~|elig;
  assign pending = pend_q;
  assign overflow = ovf_q;
endmodule
